// File: rtl/arith_stack_unit.sv
// Operand-stack execution unit: LIFO stack with PUSH/POP and signed ADD/SUB/MUL/DIV (TOS op NOS).
// Define ARITH_SAT_EN to saturate ADD/SUB/MUL/DIV results instead of wrapping.
module arith_stack_unit #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [2:0]                cmd_op,
    input  logic [DATA_W-1:0]         cmd_data,
    output logic                      done,
    output logic                      err,
    output logic [DATA_W-1:0]         tos,
    output logic [$clog2(DEPTH):0]    index,
    output logic                      empty,
    output logic                      full,
    output logic                      carry_out,
    output logic [2:0]                dbg_state
);

    // Handshake: a command is taken on a rising edge where cmd_valid && cmd_ready;
    // cmd_ready is high only in IDLE, cmd_op/cmd_data are sampled only then, and
    // requests made while busy are dropped rather than queued.

`ifdef ARITH_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam int AW = $clog2(DEPTH);
    localparam int IW = AW + 1;
    localparam int CW = $clog2(DATA_W) + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_EXEC  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;

    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;
    localparam logic [2:0] OP_ADD  = 3'd4;
    localparam logic [2:0] OP_SUB  = 3'd5;
    localparam logic [2:0] OP_MUL  = 3'd6;
    localparam logic [2:0] OP_DIV  = 3'd7;

    localparam logic [IW-1:0]       DEPTH_I   = IW'(DEPTH);
    localparam logic [IW-1:0]       ONE_I     = IW'(1);
    localparam logic [IW-1:0]       TWO_I     = IW'(2);
    localparam logic [CW-1:0]       LAST_STEP = CW'(DATA_W - 1);
    localparam logic [DATA_W-1:0]   SMAX      = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0]   SMIN      = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [2*DATA_W-1:0] PROD_HALF = {{DATA_W{1'b0}}, 1'b1, {(DATA_W-1){1'b0}}};

    function automatic logic [DATA_W-1:0] abs_val(input logic [DATA_W-1:0] v);
        return v[DATA_W-1] ? -v : v;
    endfunction

    logic [2:0]        state_q, state_d;
    logic [IW-1:0]     index_q, index_d;
    logic [2:0]        op_q, op_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [DATA_W-1:0] hi_q, hi_d;
    logic [DATA_W-1:0] lo_q, lo_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              carry_q, carry_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [AW-1:0]     mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic [AW-1:0]       tos_addr, nos_addr;
    logic [DATA_W-1:0]   mem_tos, mem_nos;
    logic [DATA_W-1:0]   mag_a, mag_b;
    logic                res_neg;
    logic [DATA_W:0]     add_full, sub_full;
    logic                add_ovf, sub_ovf;
    logic [DATA_W:0]     mul_sum;
    logic [DATA_W:0]     div_shift, div_trial;
    logic [2*DATA_W-1:0] prod_mag;
    logic [DATA_W-1:0]   mul_low, div_quot;
    logic                mul_ovf, div_ovf;
    logic [DATA_W-1:0]   wb_data;
    logic                wb_carry;

    always_comb begin
        tos_addr  = AW'(index_q - ONE_I);
        nos_addr  = AW'(index_q - TWO_I);
        mem_tos   = mem[tos_addr];
        mem_nos   = mem[nos_addr];
        mag_a     = abs_val(a_q);
        mag_b     = abs_val(b_q);
        res_neg   = a_q[DATA_W-1] ^ b_q[DATA_W-1];

        add_full  = {1'b0, a_q} + {1'b0, b_q};
        sub_full  = {1'b0, a_q} - {1'b0, b_q};
        add_ovf   = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (add_full[DATA_W-1] != a_q[DATA_W-1]);
        sub_ovf   = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (sub_full[DATA_W-1] != a_q[DATA_W-1]);

        // One shift-add step: hi accumulates, lo holds the remaining multiplier bits.
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_a} : {(DATA_W+1){1'b0}});
        // One restoring-divide step: hi is the partial remainder, lo shifts dividend out / quotient in.
        div_shift = {hi_q, lo_q[DATA_W-1]};
        div_trial = div_shift - {1'b0, mag_b};

        prod_mag  = {hi_q, lo_q};
        mul_low   = res_neg ? -lo_q : lo_q;
        mul_ovf   = res_neg ? (prod_mag > PROD_HALF) : (prod_mag >= PROD_HALF);
        div_quot  = res_neg ? -lo_q : lo_q;
        div_ovf   = !res_neg && lo_q[DATA_W-1];
    end

    always_comb begin
        wb_data  = '0;
        wb_carry = 1'b0;
        case (op_q)
            OP_ADD: begin
                wb_data  = (SAT_EN && add_ovf) ? (a_q[DATA_W-1] ? SMIN : SMAX) : add_full[DATA_W-1:0];
                wb_carry = add_full[DATA_W];
            end
            OP_SUB: begin
                wb_data  = (SAT_EN && sub_ovf) ? (a_q[DATA_W-1] ? SMIN : SMAX) : sub_full[DATA_W-1:0];
                wb_carry = sub_full[DATA_W];
            end
            OP_MUL: begin
                wb_data  = (SAT_EN && mul_ovf) ? (res_neg ? SMIN : SMAX) : mul_low;
            end
            OP_DIV: begin
                if (b_q == '0) begin
                    wb_data = '0;
                end else begin
                    wb_data = (SAT_EN && div_ovf) ? SMAX : div_quot;
                end
            end
            default: wb_data = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        carry_d   = carry_q;
        mem_we    = 1'b0;
        mem_waddr = index_q[AW-1:0];
        mem_wdata = cmd_data;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                    case (cmd_op)
                        OP_PUSH: begin
                            if (index_q == DEPTH_I) begin
                                err_d = 1'b1;
                            end else begin
                                mem_we  = 1'b1;
                                index_d = index_q + ONE_I;
                            end
                        end
                        OP_POP: begin
                            if (index_q == '0) err_d = 1'b1;
                            else               index_d = index_q - ONE_I;
                        end
                        OP_ADD, OP_SUB, OP_MUL, OP_DIV: begin
                            if (index_q < TWO_I) err_d = 1'b1;
                            else                 state_d = S_LOAD;
                        end
                        default: err_d = 1'b1;
                    endcase
                end
            end
            S_LOAD: begin
                a_d     = mem_tos;
                b_d     = mem_nos;
                index_d = index_q - TWO_I;
                hi_d    = '0;
                lo_d    = (op_q == OP_DIV) ? abs_val(mem_tos) : abs_val(mem_nos);
                cnt_d   = '0;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (op_q == OP_ADD || op_q == OP_SUB) begin
                    state_d = S_WRITE;
                end else begin
                    if (op_q == OP_MUL) begin
                        hi_d = mul_sum[DATA_W:1];
                        lo_d = {mul_sum[0], lo_q[DATA_W-1:1]};
                    end else if (!div_trial[DATA_W]) begin
                        hi_d = div_trial[DATA_W-1:0];
                        lo_d = {lo_q[DATA_W-2:0], 1'b1};
                    end else begin
                        hi_d = div_shift[DATA_W-1:0];
                        lo_d = {lo_q[DATA_W-2:0], 1'b0};
                    end
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_STEP) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                mem_we    = 1'b1;
                mem_wdata = wb_data;
                index_d   = index_q + ONE_I;
                carry_d   = wb_carry;
                err_d     = (op_q == OP_DIV) && (b_q == '0);
                state_d   = S_RESP;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            index_q <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            carry_q <= 1'b0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            carry_q <= carry_d;
        end
    end

    // Stack storage carries no reset; only index decides which entries are live.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_RESP);
    assign err       = (state_q == S_RESP) && err_q;
    assign tos       = (index_q == '0) ? '0 : mem_tos;
    assign index     = index_q;
    assign empty     = (index_q == '0);
    assign full      = (index_q == DEPTH_I);
    assign carry_out = carry_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_arith_stack_unit.sv
// Bench for arith_stack_unit: directed cases plus random command streams checked against a queue-based stack model.
module tb_arith_stack_unit;

  localparam int W     = 8;
  localparam int DEPTH = 16;
  localparam int IW    = $clog2(DEPTH) + 1;

`ifdef ARITH_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [2:0]    cmd_op = '0;
  logic [W-1:0]  cmd_data = '0;
  logic          done;
  logic          err;
  logic [W-1:0]  tos;
  logic [IW-1:0] index;
  logic          empty;
  logic          full;
  logic          carry_out;
  logic [2:0]    dbg_state;

  arith_stack_unit #(.DATA_W(W), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_data(cmd_data),
    .done(done), .err(err), .tos(tos), .index(index),
    .empty(empty), .full(full), .carry_out(carry_out), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: the stack as a queue, back = top of stack
  logic [W-1:0] model_stk[$];
  logic         model_carry = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] model_arith(input logic [2:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b, output logic c, output logic e);
    int sa, sb, ua, ub, s;
    int maxv, minv;
    logic [31:0] t;
    sa = int'($signed(a));
    sb = int'($signed(b));
    ua = int'(a);
    ub = int'(b);
    maxv = (1 << (W - 1)) - 1;
    minv = -(1 << (W - 1));
    c = 1'b0;
    e = 1'b0;
    s = 0;
    case (op)
      3'd4: begin s = sa + sb; c = (ua + ub) > ((1 << W) - 1); end
      3'd5: begin s = sa - sb; c = (ua < ub); end
      3'd6: s = sa * sb;
      default: begin
        if (sb == 0) begin
          e = 1'b1;
          return '0;
        end
        s = sa / sb;
      end
    endcase
    if (SAT) begin
      if (s > maxv) s = maxv;
      if (s < minv) s = minv;
    end
    t = s;
    return t[W-1:0];
  endfunction

  // driver: issue one command, hold junk requests while busy, return latency to done
  task automatic issue(input logic [2:0] op, input logic [W-1:0] d, output int lat, output logic got_err);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!cmd_ready) check("ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_op    = op;
    cmd_data  = d;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_op   = 3'($urandom_range(0, 7));
    cmd_data = W'($urandom);
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    cmd_valid = 1'b0;
    got_err   = err;
    if (!done) check("done_timeout", 32'(done), 32'd1);
    else       check("ready_in_done", 32'(cmd_ready), 32'd0);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] d);
    int            exp_lat, lat;
    logic          exp_err, got_err, c, e;
    logic [W-1:0]  a, b, r, exp_tos;
    exp_err = 1'b0;
    exp_lat = 1;
    case (op)
      3'd0: if (model_stk.size() == DEPTH) exp_err = 1'b1; else model_stk.push_back(d);
      3'd1: if (model_stk.size() == 0) exp_err = 1'b1; else void'(model_stk.pop_back());
      3'd4, 3'd5, 3'd6, 3'd7: begin
        if (model_stk.size() < 2) begin
          exp_err = 1'b1;
        end else begin
          a = model_stk.pop_back();
          b = model_stk.pop_back();
          r = model_arith(op, a, b, c, e);
          model_stk.push_back(r);
          model_carry = c;
          exp_err = e;
          exp_lat = (op == 3'd4 || op == 3'd5) ? 4 : 3 + W;
        end
      end
      default: exp_err = 1'b1;
    endcase
    exp_tos = (model_stk.size() == 0) ? '0 : model_stk[$];
    issue(op, d, lat, got_err);
    check($sformatf("latency op%0d", op), 32'(lat), 32'(exp_lat));
    check($sformatf("err op%0d", op), 32'(got_err), 32'(exp_err));
    check($sformatf("tos op%0d", op), 32'(tos), 32'(exp_tos));
    check($sformatf("index op%0d", op), 32'(index), 32'(model_stk.size()));
    check($sformatf("empty op%0d", op), 32'(empty), 32'(model_stk.size() == 0));
    check($sformatf("full op%0d", op), 32'(full), 32'(model_stk.size() == DEPTH));
    check($sformatf("carry op%0d", op), 32'(carry_out), 32'(model_carry));
    @(posedge clk); #1;
    check("done_pulse", 32'({done, err}), 32'd0);
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (model_stk.size() > 0 && guard < DEPTH + 2) begin
      run_op(3'd1, '0);
      guard++;
    end
  endtask

  function automatic logic [W-1:0] rand_data();
    int sel;
    sel = $urandom_range(0, 9);
    case (sel)
      0: return '0;
      1: return {1'b1, {(W-1){1'b0}}};
      2: return '1;
      3: return W'(1);
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    int seen_done, sel;
    logic [2:0] rop;

    // reset state
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_index", 32'(index), 32'd0);
    check("rst_tos", 32'(tos), 32'd0);
    check("rst_empty_full", 32'({empty, full}), 32'b10);
    check("rst_carry", 32'(carry_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // arithmetic examples
    run_op(3'd0, 8'd2); run_op(3'd0, 8'd7); run_op(3'd4, '0);
    check("ex_add", 32'(tos), 32'd9);
    drain();
    run_op(3'd0, 8'd2); run_op(3'd0, 8'd8); run_op(3'd5, '0);
    check("ex_sub_pos", 32'(tos), 32'd6);
    run_op(3'd0, 8'd6); run_op(3'd0, 8'd4); run_op(3'd5, '0);
    check("ex_sub_neg", 32'({carry_out, tos}), 32'h1FE);
    drain();
    run_op(3'd0, 8'd9); run_op(3'd0, 8'd3); run_op(3'd6, '0);
    check("ex_mul", 32'(tos), 32'h1B);
    run_op(3'd0, 8'hFF); run_op(3'd0, 8'd18); run_op(3'd6, '0);
    check("ex_mul_neg", 32'(tos), 32'hEE);
    drain();
    run_op(3'd0, 8'd27); run_op(3'd0, 8'd54); run_op(3'd7, '0);
    check("ex_div", 32'(tos), 32'd2);
    run_op(3'd0, 8'hFE); run_op(3'd0, 8'd2); run_op(3'd7, '0);
    check("ex_div_neg", 32'(tos), 32'hFF);
    drain();
    run_op(3'd0, 8'd0); run_op(3'd0, 8'd5); run_op(3'd7, '0);
    check("ex_div0", 32'({tos, index}), 32'({8'd0, 5'd1}));
    drain();
    run_op(3'd0, 8'd100); run_op(3'd0, 8'd100); run_op(3'd4, '0);
    check("ex_add_ovf", 32'(tos), SAT ? 32'd127 : 32'hC8);
    drain();
    run_op(3'd0, 8'hFF); run_op(3'd0, 8'h80); run_op(3'd7, '0);
    check("ex_div_ovf", 32'(tos), SAT ? 32'd127 : 32'h80);
    drain();

    // boundaries: fill, overflow push, drain, underflow pop, short-stack arith, reserved ops
    for (int i = 0; i < DEPTH; i++) run_op(3'd0, rand_data());
    check("full_flag", 32'(full), 32'd1);
    run_op(3'd0, 8'h55);
    check("push_full_index", 32'(index), 32'(DEPTH));
    drain();
    run_op(3'd1, '0);
    check("pop_empty_tos", 32'(tos), 32'd0);
    run_op(3'd0, 8'h33); run_op(3'd4, '0);
    check("add_short_index", 32'(index), 32'd1);
    run_op(3'd2, 8'h11); run_op(3'd3, 8'h22);

    // reset during MUL execution
    run_op(3'd0, 8'd9);
    cmd_op = 3'd6; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_index", 32'(index), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_ready", 32'(cmd_ready), 32'd1);
    check("midrst_tos", 32'(tos), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    model_stk.delete();
    model_carry = 1'b0;
    seen_done = 0;
    for (int i = 0; i < 3 + W + 2; i++) begin
      @(posedge clk); #1;
      if (done) seen_done++;
    end
    check("midrst_no_done", 32'(seen_done), 32'd0);
    check("midrst_ready_after", 32'(cmd_ready), 32'd1);

    // random command stream
    for (int n = 0; n < 400; n++) begin
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1, 2, 3: rop = 3'd0;
        4: rop = 3'd1;
        5: rop = 3'd4;
        6: rop = 3'd5;
        7: rop = 3'd6;
        8: rop = 3'd7;
        default: rop = 3'($urandom_range(2, 3));
      endcase
      run_op(rop, rand_data());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected completion");
    $fatal(1, "timeout");
  end

endmodule
